obi2wb_bridge: RTL and testbench
================================

OBI2WB_BRIDGE -- requirements
Module: obi2wb_bridge

Interface
REQ-001 SHALL have parameter AW, default 32, meaning address width in bits.
REQ-002 SHALL have parameter DW, default 32, meaning data width in bits; DW/8 byte lanes.
REQ-003 SHALL have parameter MaxOutstanding, default 4, meaning maximum accepted-but-unanswered transfers (>=1).
REQ-004 SHALL have parameter TimeoutCycles, default 1024, meaning response-wait cycles before abort; 0 disables timeout.
REQ-005 SHALL have port clk_i, input, 1, the single clock.
REQ-006 SHALL have port rst_ni, input, 1, reset; synchronous, active-low.
REQ-007 SHALL have core-side ports req_i in 1, gnt_o out 1, addr_i in AW, we_i in 1, be_i in DW/8, wdata_i in DW.
REQ-008 SHALL have core-side response ports rvalid_o out 1, rdata_o out DW, err_o out 1.
REQ-009 SHALL have Wishbone B4 pipelined master ports wb_cyc_o out 1, wb_stb_o out 1, wb_adr_o out AW, wb_dat_o out DW, wb_we_o out 1, wb_sel_o out DW/8.
REQ-010 SHALL have Wishbone inputs wb_stall_i 1, wb_ack_i 1, wb_err_i 1, wb_dat_i DW.
REQ-011 SHALL have port busy_o, output, 1, high while any transfer is outstanding or state is ABORT.

Function
REQ-012 SHALL implement states RUN and ABORT; reset state RUN.
REQ-013 SHALL keep outstanding counter cnt, width $clog2(MaxOutstanding+1), reset 0.
REQ-014 In RUN, wb_stb_o SHALL equal req_i & (cnt < MaxOutstanding), combinationally.
REQ-015 gnt_o SHALL equal wb_stb_o & ~wb_stall_i (accept event); 0 in ABORT.
REQ-016 wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o SHALL pass addr_i, wdata_i, we_i, be_i through combinationally.
REQ-017 wb_cyc_o SHALL equal wb_stb_o | (cnt != 0) in RUN, and 0 in ABORT.
REQ-018 Response event SHALL be (wb_ack_i | wb_err_i) while in RUN with cnt != 0; ack/err with cnt == 0 SHALL be ignored.
REQ-019 cnt SHALL update cnt + accept - response each cycle; simultaneous accept and response SHALL leave cnt unchanged.
REQ-020 On a response event, next cycle rvalid_o SHALL be 1, rdata_o SHALL be wb_dat_i, err_o SHALL be wb_err_i (fixed 1-cycle response latency).
REQ-021 Simultaneous wb_ack_i and wb_err_i SHALL be treated as a single error response.
REQ-022 rvalid_o SHALL be high exactly one cycle per accepted transfer, in acceptance order.
REQ-023 Timeout counter SHALL increment each RUN cycle with cnt != 0 and no response, clear on response or cnt == 0.
REQ-024 When TimeoutCycles != 0 and timeout counter reaches TimeoutCycles, state SHALL go ABORT next cycle.
REQ-025 In ABORT, each cycle SHALL emit rvalid_o=1, err_o=1, rdata_o=0 and decrement cnt; when cnt reaches 0, state SHALL return to RUN.
REQ-026 Wishbone ack/err during ABORT SHALL be ignored.
REQ-027 When cnt == MaxOutstanding, wb_stb_o and gnt_o SHALL be 0 until a response frees a slot.

Reset
REQ-028 While rst_ni is low at a clock edge: state RUN, cnt 0, timeout counter 0, rvalid_o 0, err_o 0, rdata_o 0, busy_o 0.
REQ-029 Reset mid-transfer SHALL discard all outstanding transfers without emitting responses.
REQ-030 During reset, combinational outputs SHALL follow REQ-014..017 with cnt 0.

Verification
REQ-031 Single read: req_i=1, addr_i=0x100, stall=0, ack one cycle later with dat 0xDEADBEEF -> gnt_o 1 cycle, rvalid_o 1 cycle after ack, rdata_o 0xDEADBEEF, err_o 0.
REQ-032 Back-to-back 4 writes, MaxOutstanding=4, ack delayed 3 cycles each -> 4 grants in 4 cycles, 5th request stalled, cnt peaks 4, four in-order rvalid pulses.
REQ-033 wb_stall_i high 5 cycles with req_i held -> gnt_o 0 for 5 cycles, wb_stb_o held, grant on first unstalled cycle.
REQ-034 wb_err_i with ack on 2nd of 3 reads -> rvalid_o pulses 3 times, err_o=1 only on 2nd.
REQ-035 TimeoutCycles=8, 2 accepted reads, no ack -> ABORT after 8 cycles, wb_cyc_o 0, two rvalid_o+err_o pulses, then RUN with busy_o 0.
REQ-036 rst_ni low with cnt=3 -> cnt 0, no rvalid_o, wb_cyc_o 0 next cycle when req_i low.

Source files
------------

// File: rtl/obi2wb_bridge.sv
// OBI core-side to Wishbone B4 pipelined master bridge.
// It tracks outstanding transfers and returns their responses in order. Transfers stuck past a timeout are aborted with errors.
module obi2wb_bridge #(
    parameter int unsigned AW             = 32,
    parameter int unsigned DW             = 32,
    parameter int unsigned MaxOutstanding = 4,
    parameter int unsigned TimeoutCycles  = 1024
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    // core side
    input  logic            req_i,
    output logic            gnt_o,
    input  logic [AW-1:0]   addr_i,
    input  logic            we_i,
    input  logic [DW/8-1:0] be_i,
    input  logic [DW-1:0]   wdata_i,
    output logic            rvalid_o,
    output logic [DW-1:0]   rdata_o,
    output logic            err_o,
    // wishbone side
    output logic            wb_cyc_o,
    output logic            wb_stb_o,
    output logic [AW-1:0]   wb_adr_o,
    output logic [DW-1:0]   wb_dat_o,
    output logic            wb_we_o,
    output logic [DW/8-1:0] wb_sel_o,
    input  logic            wb_stall_i,
    input  logic            wb_ack_i,
    input  logic            wb_err_i,
    input  logic [DW-1:0]   wb_dat_i,
    output logic            busy_o
);

    localparam int unsigned CW = $clog2(MaxOutstanding + 1);
    localparam int unsigned TW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
    localparam logic [CW-1:0] CntMax   = CW'(MaxOutstanding);
    localparam logic [TW-1:0] TmoLimit = TW'(TimeoutCycles);

    typedef enum logic {
        RUN   = 1'b0,
        ABORT = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          rvalid_q, rvalid_d;
    logic          err_q, err_d;
    logic [DW-1:0] rdata_q, rdata_d;

    logic in_run;
    logic cnt_nz;
    logic stb;
    logic accept;
    logic response;
    logic abort_trig;

    assign in_run   = (state_q == RUN);
    assign cnt_nz   = (cnt_q != '0);
    assign stb      = in_run & req_i & (cnt_q < CntMax);
    assign accept   = stb & ~wb_stall_i;
    // Stray ack/err with nothing outstanding must not create a response.
    assign response = in_run & cnt_nz & (wb_ack_i | wb_err_i);
    assign abort_trig = (TimeoutCycles != 0) && in_run && cnt_nz && !response
                        && (tmo_q >= TmoLimit);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        tmo_d    = tmo_q;
        rvalid_d = 1'b0;
        err_d    = 1'b0;
        rdata_d  = '0;
        case (state_q)
            RUN: begin
                cnt_d = cnt_q + CW'(accept) - CW'(response);
                if (response || !cnt_nz || (TimeoutCycles == 0)) begin
                    tmo_d = '0;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
                if (abort_trig) begin
                    state_d  = ABORT;
                    tmo_d    = '0;
                    rvalid_d = 1'b1;
                    err_d    = 1'b1;
                end else if (response) begin
                    rvalid_d = 1'b1;
                    err_d    = wb_err_i;
                    rdata_d  = wb_dat_i;
                end
            end
            ABORT: begin
                // One error response is flushed per cycle. The outputs are registered, so the
                // response for the last slot is already visible while this cycle returns to RUN.
                tmo_d = '0;
                cnt_d = cnt_nz ? (cnt_q - 1'b1) : '0;
                if (cnt_q <= CW'(1)) begin
                    state_d = RUN;
                end else begin
                    rvalid_d = 1'b1;
                    err_d    = 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= RUN;
            cnt_q    <= '0;
            tmo_q    <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            tmo_q    <= tmo_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
        end
    end

    assign gnt_o    = accept;
    assign wb_stb_o = stb;
    assign wb_cyc_o = stb | (in_run & cnt_nz);
    assign wb_adr_o = addr_i;
    assign wb_dat_o = wdata_i;
    assign wb_we_o  = we_i;
    assign wb_sel_o = be_i;
    assign rvalid_o = rvalid_q;
    assign err_o    = err_q;
    assign rdata_o  = rdata_q;
    assign busy_o   = cnt_nz | ~in_run;

endmodule

// File: tb/tb_obi2wb_bridge.sv
// Directed testbench for obi2wb_bridge (MaxOutstanding=4, TimeoutCycles=8).
module tb_obi2wb_bridge;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        req_i;
    logic        gnt_o;
    logic [31:0] addr_i;
    logic        we_i;
    logic [3:0]  be_i;
    logic [31:0] wdata_i;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic        err_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;
    logic        wb_stall_i;
    logic        wb_ack_i;
    logic        wb_err_i;
    logic [31:0] wb_dat_i;
    logic        busy_o;

    int tests = 0;
    int fails = 0;

    always #5 clk_i = ~clk_i;

    obi2wb_bridge #(
        .AW(32), .DW(32), .MaxOutstanding(4), .TimeoutCycles(8)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_i(req_i), .gnt_o(gnt_o), .addr_i(addr_i), .we_i(we_i), .be_i(be_i), .wdata_i(wdata_i),
        .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o),
        .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o),
        .wb_stall_i(wb_stall_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_dat_i(wb_dat_i),
        .busy_o(busy_o)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; req_i = 1'b0; addr_i = '0; we_i = 1'b0; be_i = 4'hF; wdata_i = '0;
        wb_stall_i = 1'b0; wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_dat_i = '0;
        tick(); tick();
        #1;
        tests++; if (rvalid_o !== 1'b0) begin fails++; $display("FAIL reset_rvalid got=%0b exp=0", rvalid_o); end
        tests++; if (err_o !== 1'b0) begin fails++; $display("FAIL reset_err got=%0b exp=0", err_o); end
        tests++; if (rdata_o !== 32'h0) begin fails++; $display("FAIL reset_rdata got=%h exp=0", rdata_o); end
        tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL reset_busy got=%0b exp=0", busy_o); end
        tests++; if (wb_cyc_o !== 1'b0) begin fails++; $display("FAIL reset_cyc got=%0b exp=0", wb_cyc_o); end
        req_i = 1'b1; addr_i = 32'h0000_0ABC; we_i = 1'b1; be_i = 4'h3; wdata_i = 32'h1234_5678;
        #1;
        tests++; if (wb_stb_o !== 1'b1 || gnt_o !== 1'b1 || wb_cyc_o !== 1'b1) begin
            fails++; $display("FAIL reset_comb stb=%0b gnt=%0b cyc=%0b exp=1,1,1", wb_stb_o, gnt_o, wb_cyc_o); end
        tests++; if (wb_adr_o !== 32'h0000_0ABC || wb_dat_o !== 32'h1234_5678 || wb_we_o !== 1'b1 || wb_sel_o !== 4'h3) begin
            fails++; $display("FAIL passthrough adr=%h dat=%h we=%0b sel=%h exp=abc,12345678,1,3",
                              wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o); end
        tick();
        req_i = 1'b0; we_i = 1'b0; be_i = 4'hF;
        #1;
        tests++; if (busy_o !== 1'b0 || rvalid_o !== 1'b0) begin
            fails++; $display("FAIL reset_accept_discard busy=%0b rvalid=%0b exp=0,0", busy_o, rvalid_o); end
        rst_ni = 1'b1;
        tick();
        $display("[TB] reset done");
    endtask

    task automatic test_single_read();
        req_i = 1'b1; addr_i = 32'h100; we_i = 1'b0;
        #1;
        tests++; if (gnt_o !== 1'b1 || wb_adr_o !== 32'h100) begin
            fails++; $display("FAIL single_gnt gnt=%0b adr=%h exp=1,100", gnt_o, wb_adr_o); end
        tick();
        req_i = 1'b0; wb_ack_i = 1'b1; wb_dat_i = 32'hDEAD_BEEF;
        #1;
        tests++; if (gnt_o !== 1'b0 || wb_cyc_o !== 1'b1 || busy_o !== 1'b1 || rvalid_o !== 1'b0) begin
            fails++; $display("FAIL single_wait gnt=%0b cyc=%0b busy=%0b rvalid=%0b exp=0,1,1,0",
                              gnt_o, wb_cyc_o, busy_o, rvalid_o); end
        tick();
        wb_ack_i = 1'b0; wb_dat_i = '0;
        #1;
        tests++; if (rvalid_o !== 1'b1 || rdata_o !== 32'hDEAD_BEEF || err_o !== 1'b0) begin
            fails++; $display("FAIL single_resp rvalid=%0b rdata=%h err=%0b exp=1,deadbeef,0", rvalid_o, rdata_o, err_o); end
        tests++; if (busy_o !== 1'b0 || wb_cyc_o !== 1'b0) begin
            fails++; $display("FAIL single_idle busy=%0b cyc=%0b exp=0,0", busy_o, wb_cyc_o); end
        tick();
        #1;
        tests++; if (rvalid_o !== 1'b0) begin fails++; $display("FAIL single_one_pulse rvalid=%0b exp=0", rvalid_o); end
        $display("[TB] single_read done");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            req_i = 1'b1; we_i = 1'b1; addr_i = 32'h200 + 32'(4 * i); wdata_i = 32'hC0DE_0000 + 32'(i);
            #1;
            tests++; if (gnt_o !== 1'b1) begin fails++; $display("FAIL b2b_gnt%0d got=%0b exp=1", i, gnt_o); end
            tick();
        end
        wb_ack_i = 1'b1; wb_dat_i = 32'h1000;
        #1;
        tests++; if (wb_stb_o !== 1'b0 || gnt_o !== 1'b0 || wb_cyc_o !== 1'b1 || busy_o !== 1'b1) begin
            fails++; $display("FAIL b2b_full stb=%0b gnt=%0b cyc=%0b busy=%0b exp=0,0,1,1",
                              wb_stb_o, gnt_o, wb_cyc_o, busy_o); end
        tick();
        req_i = 1'b0; we_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wb_ack_i = (i < 3); wb_dat_i = 32'h1001 + 32'(i);
            #1;
            tests++; if (rvalid_o !== 1'b1 || rdata_o !== 32'h1000 + 32'(i) || err_o !== 1'b0) begin
                fails++; $display("FAIL b2b_resp%0d rvalid=%0b rdata=%h err=%0b exp=1,%h,0",
                                  i, rvalid_o, rdata_o, err_o, 32'h1000 + 32'(i)); end
            tick();
        end
        wb_ack_i = 1'b0;
        #1;
        tests++; if (rvalid_o !== 1'b0 || busy_o !== 1'b0) begin
            fails++; $display("FAIL b2b_drain rvalid=%0b busy=%0b exp=0,0", rvalid_o, busy_o); end
        $display("[TB] back_to_back done");
    endtask

    task automatic test_stall();
        req_i = 1'b1; we_i = 1'b0; addr_i = 32'h300; wb_stall_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            tests++; if (gnt_o !== 1'b0 || wb_stb_o !== 1'b1 || wb_cyc_o !== 1'b1) begin
                fails++; $display("FAIL stall%0d gnt=%0b stb=%0b cyc=%0b exp=0,1,1", i, gnt_o, wb_stb_o, wb_cyc_o); end
            tick();
        end
        wb_stall_i = 1'b0;
        #1;
        tests++; if (gnt_o !== 1'b1) begin fails++; $display("FAIL stall_release gnt=%0b exp=1", gnt_o); end
        tick();
        req_i = 1'b0; wb_ack_i = 1'b1; wb_dat_i = 32'h5A5A_5A5A;
        tick();
        wb_ack_i = 1'b0;
        #1;
        tests++; if (rvalid_o !== 1'b1 || rdata_o !== 32'h5A5A_5A5A) begin
            fails++; $display("FAIL stall_resp rvalid=%0b rdata=%h exp=1,5a5a5a5a", rvalid_o, rdata_o); end
        tick();
        $display("[TB] stall done");
    endtask

    task automatic test_error();
        for (int i = 0; i < 5; i++) begin
            req_i = (i < 3); addr_i = 32'h400 + 32'(4 * i); we_i = 1'b0;
            wb_ack_i = (i >= 1 && i <= 3); wb_err_i = (i == 2); wb_dat_i = 32'hA0 + 32'(i) - 32'd1;
            #1;
            tests++; if (gnt_o !== (i < 3)) begin fails++; $display("FAIL err_gnt%0d got=%0b exp=%0b", i, gnt_o, (i < 3)); end
            if (i >= 2) begin
                tests++; if (rvalid_o !== 1'b1 || err_o !== (i == 3) || rdata_o !== 32'hA0 + 32'(i) - 32'd2) begin
                    fails++; $display("FAIL err_resp%0d rvalid=%0b err=%0b rdata=%h exp=1,%0b,%h",
                                      i, rvalid_o, err_o, rdata_o, (i == 3), 32'hA0 + 32'(i) - 32'd2); end
            end else begin
                tests++; if (rvalid_o !== 1'b0) begin fails++; $display("FAIL err_early%0d rvalid=%0b exp=0", i, rvalid_o); end
            end
            tick();
        end
        wb_ack_i = 1'b1; wb_err_i = 1'b1;
        #1;
        tests++; if (wb_cyc_o !== 1'b0) begin fails++; $display("FAIL stray_cyc got=%0b exp=0", wb_cyc_o); end
        tick();
        wb_ack_i = 1'b0; wb_err_i = 1'b0;
        #1;
        tests++; if (rvalid_o !== 1'b0 || busy_o !== 1'b0) begin
            fails++; $display("FAIL stray_ignored rvalid=%0b busy=%0b exp=0,0", rvalid_o, busy_o); end
        $display("[TB] error done");
    endtask

    task automatic test_timeout();
        for (int i = 0; i < 13; i++) begin
            req_i = (i < 2) || (i == 10); addr_i = 32'h500; we_i = 1'b0;
            wb_ack_i = (i == 10) || (i == 11); wb_dat_i = 32'hFFFF_FFFF;
            #1;
            if (i < 2) begin
                tests++; if (gnt_o !== 1'b1) begin fails++; $display("FAIL tmo_gnt%0d got=%0b exp=1", i, gnt_o); end
            end else if (i <= 9) begin
                tests++; if (rvalid_o !== 1'b0 || wb_cyc_o !== 1'b1 || busy_o !== 1'b1) begin
                    fails++; $display("FAIL tmo_wait%0d rvalid=%0b cyc=%0b busy=%0b exp=0,1,1",
                                      i, rvalid_o, wb_cyc_o, busy_o); end
            end else if (i <= 11) begin
                tests++; if (rvalid_o !== 1'b1 || err_o !== 1'b1 || rdata_o !== 32'h0) begin
                    fails++; $display("FAIL tmo_abort%0d rvalid=%0b err=%0b rdata=%h exp=1,1,0",
                                      i, rvalid_o, err_o, rdata_o); end
                tests++; if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || gnt_o !== 1'b0 || busy_o !== 1'b1) begin
                    fails++; $display("FAIL tmo_abort_bus%0d cyc=%0b stb=%0b gnt=%0b busy=%0b exp=0,0,0,1",
                                      i, wb_cyc_o, wb_stb_o, gnt_o, busy_o); end
            end else begin
                tests++; if (rvalid_o !== 1'b0 || busy_o !== 1'b0 || wb_cyc_o !== 1'b0) begin
                    fails++; $display("FAIL tmo_done rvalid=%0b busy=%0b cyc=%0b exp=0,0,0", rvalid_o, busy_o, wb_cyc_o); end
            end
            tick();
        end
        wb_ack_i = 1'b0; req_i = 1'b0;
        $display("[TB] timeout done");
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            req_i = 1'b1; addr_i = 32'h600 + 32'(4 * i);
            tick();
        end
        req_i = 1'b0; rst_ni = 1'b0;
        #1;
        tests++; if (wb_cyc_o !== 1'b1 || busy_o !== 1'b1) begin
            fails++; $display("FAIL rstmid_before cyc=%0b busy=%0b exp=1,1", wb_cyc_o, busy_o); end
        tick();
        #1;
        tests++; if (wb_cyc_o !== 1'b0 || busy_o !== 1'b0 || rvalid_o !== 1'b0) begin
            fails++; $display("FAIL rstmid_after cyc=%0b busy=%0b rvalid=%0b exp=0,0,0", wb_cyc_o, busy_o, rvalid_o); end
        rst_ni = 1'b1; wb_ack_i = 1'b1;
        tick();
        wb_ack_i = 1'b0;
        #1;
        tests++; if (rvalid_o !== 1'b0 || busy_o !== 1'b0) begin
            fails++; $display("FAIL rstmid_no_resp rvalid=%0b busy=%0b exp=0,0", rvalid_o, busy_o); end
        tick();
        $display("[TB] reset_mid done");
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_back_to_back();
        test_stall();
        test_error();
        test_timeout();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired tests=%0d", tests);
        $fatal(1, "watchdog");
    end

endmodule
